// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues one imem request at a time, presents fetched words to IF/ID.
// Optional MISALIGN_TRAP_EN: misaligned redirect targets trap to TRAP_VECTOR and pulse io_misaligned.
module fetch_sequencer #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0]   TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_stall,
    input  logic            io_redirect_valid,
    input  logic [XLEN-1:0] io_redirect_target,
    output logic            io_imem_req_valid,
    input  logic            io_imem_req_ready,
    output logic [XLEN-1:0] io_imem_req_addr,
    input  logic            io_imem_resp_valid,
    input  logic [31:0]     io_imem_resp_data,
    output logic            io_if_valid,
    output logic [XLEN-1:0] io_if_pc,
    output logic [XLEN-1:0] io_if_pc4,
    output logic [31:0]     io_if_inst,
    output logic            io_flush
`ifdef MISALIGN_TRAP_EN
    ,
    output logic            io_misaligned
`endif
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_PRES = 2'd2;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [31:0]     NOP     = 32'h0000_0013;

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_kill;
    logic            r_if_valid;
    logic [XLEN-1:0] r_if_pc;
    logic [XLEN-1:0] r_if_pc4;
    logic [31:0]     r_if_inst;

    logic [XLEN-1:0] w_pc4;
    logic [XLEN-1:0] w_tgt_aligned;
    logic [XLEN-1:0] w_new_pc;

    assign w_pc4         = r_pc + PC_STEP;
    assign w_tgt_aligned = {io_redirect_target[XLEN-1:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
    logic w_mis;
    assign w_mis         = io_redirect_valid && (io_redirect_target[1:0] != 2'b00);
    assign w_new_pc      = w_mis ? TRAP_VECTOR : w_tgt_aligned;
    assign io_misaligned = w_mis && !reset;
`else
    // Low target bits and the trap vector only matter when the trap is built in.
    logic w_unused_lowbits;
    assign w_unused_lowbits = ^{io_redirect_target[1:0], TRAP_VECTOR};
    assign w_new_pc         = w_tgt_aligned;
`endif

    assign io_imem_req_valid = (r_state == S_REQ) && !reset;
    assign io_imem_req_addr  = r_pc;
    assign io_flush          = io_redirect_valid && !reset;
    assign io_if_valid       = r_if_valid;
    assign io_if_pc          = r_if_pc;
    assign io_if_pc4         = r_if_pc4;
    assign io_if_inst        = r_if_inst;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_VECTOR;
            r_kill     <= 1'b0;
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_pc4   <= '0;
            r_if_inst  <= NOP;
        end else begin
            case (r_state)
                S_REQ: begin
                    // An accepted request that is redirected away must have its response dropped.
                    if (io_redirect_valid) begin
                        r_pc <= w_new_pc;
                        if (io_imem_req_ready) begin
                            r_kill  <= 1'b1;
                            r_state <= S_WAIT;
                        end
                    end else if (io_imem_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (io_imem_resp_valid) begin
                        r_kill <= 1'b0;
                        if (io_redirect_valid) begin
                            r_pc    <= w_new_pc;
                            r_state <= S_REQ;
                        end else if (r_kill) begin
                            r_state <= S_REQ;
                        end else begin
                            r_if_pc    <= r_pc;
                            r_if_pc4   <= w_pc4;
                            r_if_inst  <= io_imem_resp_data;
                            r_if_valid <= 1'b1;
                            r_state    <= S_PRES;
                        end
                    end else if (io_redirect_valid) begin
                        r_kill <= 1'b1;
                        r_pc   <= w_new_pc;
                    end
                end
                S_PRES: begin
                    if (io_redirect_valid) begin
                        r_pc       <= w_new_pc;
                        r_if_valid <= 1'b0;
                        r_state    <= S_REQ;
                    end else if (!io_stall) begin
                        r_pc       <= w_pc4;
                        r_if_valid <= 1'b0;
                        r_state    <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, then random stimulus against a transaction-level model.
module tb_fetch_sequencer;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] TRAP = 32'h0000_0100;
    localparam logic [31:0] D0   = 32'h00A0_0093;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_stall, io_redirect_valid, io_imem_req_ready, io_imem_resp_valid;
    logic [31:0] io_redirect_target, io_imem_resp_data;
    logic        io_imem_req_valid, io_if_valid, io_flush;
    logic [31:0] io_imem_req_addr, io_if_pc, io_if_pc4, io_if_inst;
`ifdef MISALIGN_TRAP_EN
    logic        io_misaligned;
`endif

    fetch_sequencer dut (
        .clock(clock), .reset(reset), .io_stall(io_stall),
        .io_redirect_valid(io_redirect_valid), .io_redirect_target(io_redirect_target),
        .io_imem_req_valid(io_imem_req_valid), .io_imem_req_ready(io_imem_req_ready),
        .io_imem_req_addr(io_imem_req_addr), .io_imem_resp_valid(io_imem_resp_valid),
        .io_imem_resp_data(io_imem_resp_data), .io_if_valid(io_if_valid),
        .io_if_pc(io_if_pc), .io_if_pc4(io_if_pc4), .io_if_inst(io_if_inst),
        .io_flush(io_flush)
`ifdef MISALIGN_TRAP_EN
        , .io_misaligned(io_misaligned)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst, stall, rv;
        logic [31:0] tgt;
        logic        rdy, respv;
        logic [31:0] data;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_ifv;
        logic [31:0] e_pc, e_pc4, e_inst;
        logic        e_flush, e_mis;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic rst, stall, rv, input logic [31:0] tgt,
                                input logic rdy, respv, input logic [31:0] data,
                                input logic er, input logic [31:0] ea, input logic eiv,
                                input logic [31:0] ep, ep4, ei, input logic ef, em);
        vec_t v;
        v.rst = rst; v.stall = stall; v.rv = rv; v.tgt = tgt; v.rdy = rdy; v.respv = respv;
        v.data = data; v.e_req = er; v.e_addr = ea; v.e_ifv = eiv; v.e_pc = ep; v.e_pc4 = ep4;
        v.e_inst = ei; v.e_flush = ef; v.e_mis = em;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic rst, stall, rv, input logic [31:0] tgt,
                         input logic rdy, respv, input logic [31:0] data);
        reset = rst; io_stall = stall; io_redirect_valid = rv; io_redirect_target = tgt;
        io_imem_req_ready = rdy; io_imem_resp_valid = respv; io_imem_resp_data = data;
    endtask

    task automatic check_outs(input logic er, input logic [31:0] ea, input logic eiv,
                              input logic [31:0] ep, ep4, ei, input logic ef, em);
        chk("req_valid", 32'(io_imem_req_valid), 32'(er));
        chk("req_addr",  io_imem_req_addr, ea);
        chk("if_valid",  32'(io_if_valid), 32'(eiv));
        chk("if_pc",     io_if_pc, ep);
        chk("if_pc4",    io_if_pc4, ep4);
        chk("if_inst",   io_if_inst, ei);
        chk("flush",     32'(io_flush), 32'(ef));
`ifdef MISALIGN_TRAP_EN
        chk("misaligned", 32'(io_misaligned), 32'(em));
`else
        if (em === 1'bx) $display("note: unexpected X in misaligned expectation");
`endif
    endtask

    // Reference model: a request is either being offered, outstanding at imem, or its
    // instruction is being shown to IF/ID; a redirect poisons an outstanding request.
    logic [31:0] m_pc, m_ifpc, m_ifpc4, m_inst;
    logic        m_outstanding, m_poisoned, m_showing;

    function automatic logic [31:0] redirect_pc(input logic [31:0] tgt);
`ifdef MISALIGN_TRAP_EN
        if (tgt % 4 != 0) return TRAP;
`endif
        return tgt - (tgt % 4);
    endfunction

    task automatic model_step(input logic rst, stall, rv, input logic [31:0] tgt,
                              input logic rdy, respv, input logic [31:0] data);
        if (rst) begin
            m_pc = 32'h0; m_outstanding = 0; m_poisoned = 0; m_showing = 0;
            m_ifpc = 0; m_ifpc4 = 0; m_inst = NOP;
        end else if (m_showing) begin
            if (rv)          begin m_pc = redirect_pc(tgt); m_showing = 0; end
            else if (!stall) begin m_pc = m_pc + 4;         m_showing = 0; end
        end else if (m_outstanding) begin
            if (respv) begin
                if (!rv && !m_poisoned) begin
                    m_ifpc = m_pc; m_ifpc4 = m_pc + 4; m_inst = data; m_showing = 1;
                end
                m_outstanding = 0; m_poisoned = 0;
            end else if (rv) begin
                m_poisoned = 1;
            end
            if (rv) m_pc = redirect_pc(tgt);
        end else begin
            if (rdy) begin m_outstanding = 1; m_poisoned = rv; end
            if (rv) m_pc = redirect_pc(tgt);
        end
    endtask

    initial begin
        vecs.push_back(mk(1,0,0,0,0,0,0,                   0,0,0,0,0,NOP,0,0));
        vecs.push_back(mk(0,0,0,0,1,0,0,                   1,0,0,0,0,NOP,0,0));
        vecs.push_back(mk(0,0,0,0,1,1,D0,                  0,0,0,0,0,NOP,0,0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,1,0,0,1,0,0,               0,0,1,0,4,D0,0,0));
        vecs.push_back(mk(0,0,0,0,1,0,0,                   0,0,1,0,4,D0,0,0));
        vecs.push_back(mk(0,0,0,0,1,0,0,                   1,4,0,0,4,D0,0,0));
        vecs.push_back(mk(0,0,1,32'h200,0,0,0,             0,4,0,0,4,D0,1,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,                   0,32'h200,0,0,4,D0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,32'hDEADBEEF,        0,32'h200,0,0,4,D0,0,0));
        vecs.push_back(mk(0,0,0,0,1,0,0,                   1,32'h200,0,0,4,D0,0,0));
        vecs.push_back(mk(0,0,1,32'h40,0,1,32'h11111111,   0,32'h200,0,0,4,D0,1,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,                   1,32'h40,0,0,4,D0,0,0));
        vecs.push_back(mk(0,0,0,0,1,0,0,                   1,32'h40,0,0,4,D0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,32'h22222222,        0,32'h40,0,0,4,D0,0,0));
        vecs.push_back(mk(0,1,1,32'h80,0,0,0,              0,32'h40,1,32'h40,32'h44,32'h22222222,1,0));
        vecs.push_back(mk(0,0,0,0,1,0,0,                   1,32'h80,0,32'h40,32'h44,32'h22222222,0,0));
        vecs.push_back(mk(0,0,1,32'hFFFFFFFC,0,0,0,        0,32'h80,0,32'h40,32'h44,32'h22222222,1,0));
        vecs.push_back(mk(0,0,0,0,0,1,32'h33333333,        0,32'hFFFFFFFC,0,32'h40,32'h44,32'h22222222,0,0));
        vecs.push_back(mk(0,0,0,0,1,0,0,                   1,32'hFFFFFFFC,0,32'h40,32'h44,32'h22222222,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,32'h44444444,        0,32'hFFFFFFFC,0,32'h40,32'h44,32'h22222222,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,                   0,32'hFFFFFFFC,1,32'hFFFFFFFC,0,32'h44444444,0,0));
        vecs.push_back(mk(0,0,0,0,1,0,0,                   1,0,0,32'hFFFFFFFC,0,32'h44444444,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,                   0,0,0,32'hFFFFFFFC,0,32'h44444444,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,32'h55555555,        1,0,0,0,0,NOP,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,                   1,0,0,0,0,NOP,0,0));
        vecs.push_back(mk(0,0,1,32'h102,1,0,0,             1,0,0,0,0,NOP,1,1));
        vecs.push_back(mk(0,0,0,0,0,1,32'h66666666,        0,32'h100,0,0,0,NOP,0,0));
        vecs.push_back(mk(0,0,0,0,1,0,0,                   1,32'h100,0,0,0,NOP,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,32'h77777777,        0,32'h100,0,0,0,NOP,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,                   0,32'h100,1,32'h100,32'h104,32'h77777777,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,                   1,32'h104,0,32'h100,32'h104,32'h77777777,0,0));

        drive(1,0,0,0,0,0,0);
        repeat (2) @(posedge clock);
        #1;
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].rv, vecs[i].tgt,
                  vecs[i].rdy, vecs[i].respv, vecs[i].data);
            #1;
            check_outs(vecs[i].e_req, vecs[i].e_addr, vecs[i].e_ifv, vecs[i].e_pc,
                       vecs[i].e_pc4, vecs[i].e_inst, vecs[i].e_flush, vecs[i].e_mis);
            @(posedge clock);
            #1;
        end

        // Known state after the table: offering a fetch of 0x104.
        m_pc = 32'h104; m_outstanding = 0; m_poisoned = 0; m_showing = 0;
        m_ifpc = 32'h100; m_ifpc4 = 32'h104; m_inst = 32'h77777777;

        for (int c = 0; c < 3000; c++) begin
            logic        rst, stall, rv, rdy, respv;
            logic [31:0] tgt, data;
            rst   = ($urandom_range(0, 99) == 0);
            stall = ($urandom_range(0, 1) == 1);
            rv    = ($urandom_range(0, 9) == 0);
            tgt   = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFFC | 32'($urandom_range(0, 3)))
                                                 : $urandom;
            rdy   = ($urandom_range(0, 9) < 6);
            respv = ($urandom_range(0, 9) < 4);
            data  = $urandom;
            drive(rst, stall, rv, tgt, rdy, respv, data);
            #1;
            check_outs(!rst && !m_outstanding && !m_showing, m_pc, m_showing,
                       m_ifpc, m_ifpc4, m_inst, !rst && rv, !rst && rv && (tgt[1:0] != 2'b00));
            model_step(rst, stall, rv, tgt, rdy, respv, data);
            @(posedge clock);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the instruction-fetch stage of the RV32 core: owns the program counter and issues one instruction-memory request at a time.
- Presents each fetched instruction, its PC and PC+4 to the IF/ID pipeline registers, including the PC4 register.
- Handles hazard-unit stalls and branch/jump redirects, discarding in-flight fetches on redirect.
- Sits between imem and the IF/ID register bank.

Parameters:
- XLEN, 32: datapath/address width.
- RESET_VECTOR, 32'h0000_0000: first fetch address after reset.
- TRAP_VECTOR, 32'h0000_0100: redirect address on misaligned target; used only with MISALIGN_TRAP_EN.

Ports:
- clock  in  1: single clock, all state on posedge.
- reset  in  1: synchronous, active-high.
- io_stall  in  1: hazard unit holds IF/ID.
- io_redirect_valid  in  1: branch/jump taken this cycle.
- io_redirect_target  in  XLEN: new PC.
- io_imem_req_valid  out  1: fetch request.
- io_imem_req_ready  in  1: imem accepts request.
- io_imem_req_addr  out  XLEN: fetch address (= pc).
- io_imem_resp_valid  in  1: instruction returned.
- io_imem_resp_data  in  32: instruction word.
- io_if_valid  out  1: instruction presented to IF/ID.
- io_if_pc  out  XLEN: PC of presented instruction.
- io_if_pc4  out  XLEN: io_if_pc + 4, feeds PC4 register.
- io_if_inst  out  32: presented instruction.
- io_flush  out  1: one-cycle pulse; IF/ID must invalidate.

Behaviour:
- Reset values (the cycle after reset is sampled high): state=REQ; pc=RESET_VECTOR; kill=0; io_imem_req_valid=0 during reset then 1; io_if_valid=0; io_if_pc=0; io_if_pc4=0; io_if_inst=32'h0000_0013 (NOP); io_flush=0.
- Reset mid-operation discards any outstanding request. A late imem response is ignored because state≠WAIT.
- States:
  - REQ: drive req_valid=1, addr=pc. On req_ready, go to WAIT.
  - WAIT: wait for resp_valid. On resp: load if_pc=pc, if_pc4=pc+4, if_inst=resp_data, and set if_valid=1 (registered, visible next cycle). Go to PRESENT.
  - PRESENT: hold if_* while io_stall=1. On stall=0: pc<=pc+4, if_valid<=0, go to REQ.
- Min latency: 3 cycles per instruction with zero-wait imem (REQ→WAIT→PRESENT).
- Redirect has priority over stall and over response in every state. It pulses io_flush for the same cycle and forces pc<=target with target[1:0] cleared:
  - REQ, with or without req_ready the same cycle: if accepted, set kill=1 and go to WAIT; else stay in REQ with the new address.
  - WAIT, no resp: kill<=1, stay in WAIT.
  - WAIT with resp the same cycle: discard resp, go to REQ.
  - PRESENT: if_valid<=0, go to REQ.
- In WAIT with kill=1: the arriving resp is discarded, kill<=0, go to REQ (fetches the redirected pc). if_valid stays 0.
- io_imem_req_addr is stable while req_valid=1 and ready=0, except on redirect.
- Arithmetic: pc+4 is modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0. if_pc4 is computed the same way.
- Stall in REQ or WAIT has no effect; stall only holds PRESENT.
- At most one outstanding imem request.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Adds output io_misaligned (1 bit, reset 0).
  - A redirect with target[1:0]≠0 pulses io_misaligned and io_flush, and sets pc<=TRAP_VECTOR instead of the target.
- Undefined: no io_misaligned port; target low bits are silently cleared.

Test Plan:
- Reset release, imem always ready, resp one cycle after accept, data 32'h00A00093 → first req_addr=0x0; if_valid=1 with if_pc=0x0, if_pc4=0x4, if_inst=32'h00A00093; next req_addr=0x4.
- io_stall=1 for 5 cycles while in PRESENT → if_* unchanged for 5 cycles, no new imem request; req_addr=pc+4 on the cycle after stall drops.
- Redirect target 0x200 while in WAIT with resp 2 cycles later → io_flush pulse; late resp discarded (if_valid stays 0); next req_addr=0x200.
- Redirect and resp_valid in the same cycle, plus stall=1 during PRESENT with redirect 0x40 → both discard/drop; next req_addr=0x40; io_flush=1 for exactly 1 cycle each time.
- pc=32'hFFFF_FFFC fetch → if_pc4=0x0, next req_addr=0x0; reset asserted in WAIT → if_valid=0, next req_addr=RESET_VECTOR.
- MISALIGN_TRAP_EN defined, redirect target 0x102 → io_misaligned=1 for 1 cycle, next req_addr=0x100 (TRAP_VECTOR); macro undefined → next req_addr=0x100 via bit-clear.
